// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit full adder.
// Operands and carry-in are captured on an accepted start.
// The block then processes one bit per clock, LSB first, through a single
// full-adder slice. A one-cycle done pulse marks the registered result.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input.
// With sub=1 the block computes a-b-cin, where cin is a borrow-in
// and cout is the inverted borrow-out.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] b_ld;
    logic             carry_ld;

    // Single full-adder slice operating on the current LSBs and the carry flop.
    always_comb begin
        s_bit       = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_shifted = {s_bit, sum_sh[WIDTH-1:1]};
    end

    // Operand conditioning at load time; subtraction is a + ~b + ~borrow.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_ld     = sub ? ~b : b;
        carry_ld = sub ? ~cin : cin;
`else
        b_ld     = b;
        carry_ld = cin;
`endif
    end

    // Next-state logic; a start is accepted in IDLE and DONE only.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = (state == RUN) && (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift registers, carry flop, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b_ld;
                carry <= carry_ld;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                carry  <= carry_nxt;
                sum_sh <= sum_shifted;
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (last_bit) begin
                    sum  <= sum_shifted;
                    cout <= carry_nxt;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit full adder. It is the additive counterpart of the team's full-subtractor cell.
- Captures two operands and a carry-in on a start strobe.
- Processes one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, such as checksum and accumulator paths.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  sole clock; all logic updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only when the block is not busy.
a  input  WIDTH  operand A; sampled on the accepted start edge.
b  input  WIDTH  operand B; sampled on the accepted start edge.
cin  input  1  carry-in; sampled on the accepted start edge.
busy  output  1  high while serial bits are being processed.
done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
Reset (rst=1 at an edge):
- State goes to IDLE.
- busy=0, done=0, sum=0, cout=0.
- Internal shift registers, carry flip-flop and bit counter are cleared.
- Reset has priority over every other event. If asserted mid-operation, the operation is aborted and no done pulse follows.

States: IDLE, RUN, DONE.

IDLE, or DONE, with start=1:
- a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, busy<=1, next state RUN.
- Inputs are not sampled at any other time. Changes to a, b or cin during RUN have no effect.

IDLE with start=0: remain in IDLE.

RUN, on every edge:
- Bit s = a_sh[0]^b_sh[0]^carry.
- carry <= majority(a_sh[0], b_sh[0], carry).
- s is shifted into sum_sh at the MSB; a_sh and b_sh shift right.
- cnt increments.
- start is ignored throughout RUN.

RUN, on the edge where cnt==WIDTH-1:
- sum <= {s, sum_sh[WIDTH-1:1]}.
- cout <= carry_next.
- busy<=0, done<=1, next state DONE.

DONE (exactly one cycle):
- done<=0 at the next edge.
- Next state is IDLE, or RUN if start=1 (back-to-back restart).

Timing:
- Accepted start at edge k gives busy high after edges k .. k+WIDTH-1.
- done is high for the single cycle following edge k+WIDTH.
- Latency is WIDTH clocks from the start edge to done.

Output holding:
- sum and cout hold their value until the next completed operation.
- A new start does not clear them.
- done is never high while busy is high.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start. When sub=1:
  - b_sh loads ~b and carry loads ~cin, where cin acts as borrow-in.
  - Result: sum = (a-b-cin) mod 2^WIDTH; cout = NOT borrow-out (cout=1 means no borrow).
  - When sub=0, behaviour is identical to the macro-undefined build.
- Undefined: no sub port, addition only.

Test Plan:
- WIDTH=8, rst pulse -> busy=0, done=0, sum=0x00, cout=0 at the first post-reset cycle.
- a=0x5A, b=0x33, cin=0, start for one cycle -> busy for 8 cycles, then done for 1 cycle with sum=0x8D, cout=0.
- Boundary carries:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start handling:
  - start re-asserted with new operands at RUN cycle 3 -> ignored; result is still from the original operands.
  - start asserted in the DONE cycle with a=0x01, b=0x02 -> second done exactly 8 cycles later with sum=0x03; no idle gap.
- rst asserted at RUN cycle 4 -> no done pulse; outputs zero. The next start then completes normally.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01, cin=0 -> sum=0x0F, cout=1.
  - sub=1, a=0x00, b=0x01, cin=0 -> sum=0xFF, cout=0.
